// File: rtl/bcd_time_pkg.sv
// ---------------------------------------------------------------------------
// bcd_time_pkg
// Shared types, constants and helpers for the BCD time-of-day keeper.
//   state_t        : controller states (RUN, LOAD)
//   ASCII_ZERO     : ASCII code of character '0'
//   *_MAX          : BCD digit / field limits
//   RST_TIME_*     : time shown after reset in each hour mode
//   bcd_inc        : increment a two-digit packed BCD value (no wrap check)
//   bcd_valid      : check a packed {H1,H0,M1,M0,S1,S0} value for legality
// ---------------------------------------------------------------------------
package bcd_time_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [3:0]  DIGIT_MAX   = 4'd9;
    localparam logic [3:0]  TENS_MAX    = 4'd5;
    localparam logic [7:0]  HOUR24_MAX  = 8'h23;
    localparam logic [7:0]  HOUR12_MAX  = 8'h12;
    localparam logic [23:0] RST_TIME_24 = 24'h000000;
    localparam logic [23:0] RST_TIME_12 = 24'h120000;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == DIGIT_MAX) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Hour ranges are compared as packed BCD bytes; this orders correctly
    // once every digit is known to be 0..9.
    function automatic logic bcd_valid(input logic [23:0] t, input logic h12);
        for (int i = 0; i < 6; i++) begin
            if (t[4*i +: 4] > DIGIT_MAX) begin
                return 1'b0;
            end
        end
        if ((t[15:12] > TENS_MAX) || (t[7:4] > TENS_MAX)) begin
            return 1'b0;
        end
        if (h12) begin
            return (t[23:16] != 8'h00) && (t[23:16] <= HOUR12_MAX);
        end
        return t[23:16] <= HOUR24_MAX;
    endfunction

endpackage

// File: rtl/bcd_time_keeper_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Combinational next-value logic for one two-digit BCD field (seconds or
// minutes). The register itself lives in the parent.
//   value       in  8 : current packed BCD field
//   inc         in  1 : advance this field by one
//   value_next  out 8 : field value after this cycle
//   carry       out 1 : field wrapped from MAX to WRAP (increment next field)
// Parameters: MAX = terminal value, WRAP = value following MAX.
// ---------------------------------------------------------------------------
module bcd_mod_counter
    import bcd_time_pkg::*;
#(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] WRAP = 8'h00
) (
    input  logic [7:0] value,
    input  logic       inc,
    output logic [7:0] value_next,
    output logic       carry
);

    assign carry = inc && (value == MAX);

    always_comb begin
        value_next = value;
        if (inc) begin
            value_next = (value == MAX) ? WRAP : bcd_inc(value);
        end
    end

endmodule

// File: rtl/bcd_time_keeper.sv
// ---------------------------------------------------------------------------
// bcd_time_keeper
// BCD HH:MM:SS time-of-day counter with prescaler, 24 h / 12 h modes,
// validated set-time handshake and a registered "HH:MM:SS" ASCII image.
//   clko       in  1  : clock
//   rst        in  1  : asynchronous active-low reset
//   en         in  1  : run enable (freezes prescaler and time when low)
//   set_valid  in  1  : set request; accepted when set_ready is high
//   set_time   in  24 : BCD {H1,H0,M1,M0,S1,S0} to load
//   set_pm     in  1  : PM value to load (12 h mode only)
//   set_ready  out 1  : high in RUN; low during the single LOAD cycle
//   set_err    out 1  : one-cycle pulse after an invalid load
//   hms        out 24 : current time, packed BCD
//   pm         out 1  : PM flag (always 0 in 24 h mode)
//   sec_pulse  out 1  : one-cycle pulse alongside each time advance
//   ascii      out 64 : "HH:MM:SS", hours-tens character in [63:56]
//   state      out    : controller state (RUN / LOAD)
// Optional (macro BCD_TIME_KEEPER_ALARM_EN):
//   alarm_we   in  1  : store alarm_time/alarm_pm
//   alarm_time in  24 : alarm time, packed BCD (not validated)
//   alarm_pm   in  1  : alarm PM flag
//   alarm_fire out 1  : pulse one cycle after a tick lands on the alarm
// Handshake: a request transfers on the rising clko edge where set_valid and
// set_ready are both high; set_time/set_pm are captured on that edge and the
// result (new time or set_err) is visible after the following edge.
// ---------------------------------------------------------------------------
module bcd_time_keeper
    import bcd_time_pkg::*;
#(
    parameter int unsigned DIV = 1,
    parameter int          H12 = 0,
    parameter logic [7:0]  SEP = 8'h3A
) (
    input  logic        clko,
    input  logic        rst,
    input  logic        en,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    input  logic        set_pm,
    output logic        set_ready,
    output logic        set_err,
    output logic [23:0] hms,
    output logic        pm,
    output logic        sec_pulse,
    output logic [63:0] ascii,
`ifdef BCD_TIME_KEEPER_ALARM_EN
    input  logic        alarm_we,
    input  logic [23:0] alarm_time,
    input  logic        alarm_pm,
    output logic        alarm_fire,
`endif
    output state_t      state
);

    localparam logic          MODE12   = (H12 != 0);
    localparam logic [23:0]   RST_TIME = MODE12 ? RST_TIME_12 : RST_TIME_24;
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);

    function automatic logic [63:0] to_ascii(input logic [23:0] t);
        return {ASCII_ZERO + {4'h0, t[23:20]}, ASCII_ZERO + {4'h0, t[19:16]}, SEP,
                ASCII_ZERO + {4'h0, t[15:12]}, ASCII_ZERO + {4'h0, t[11:8]},  SEP,
                ASCII_ZERO + {4'h0, t[7:4]},   ASCII_ZERO + {4'h0, t[3:0]}};
    endfunction

    state_t        state_next;
    logic [CW-1:0] count;
    logic [23:0]   pend_time;
    logic          pend_pm;
    logic          accept;
    logic          tick;
    logic          load_ok;
    logic [7:0]    sec_next;
    logic [7:0]    min_next;
    logic [7:0]    hr_next;
    logic          pm_next;
    logic          sec_carry;
    logic          min_carry;

    assign set_ready = (state == RUN);
    assign accept    = set_valid && set_ready;
    // LOAD never ticks, so the prescaler naturally holds for that cycle.
    assign tick      = (state == RUN) && en && (count == LAST);
    assign load_ok   = (state == LOAD) && bcd_valid(pend_time, MODE12);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept) state_next = LOAD;
            LOAD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    bcd_mod_counter #(.MAX({TENS_MAX, DIGIT_MAX}), .WRAP(8'h00)) u_sec (
        .value      (hms[7:0]),
        .inc        (tick),
        .value_next (sec_next),
        .carry      (sec_carry)
    );

    bcd_mod_counter #(.MAX({TENS_MAX, DIGIT_MAX}), .WRAP(8'h00)) u_min (
        .value      (hms[15:8]),
        .inc        (sec_carry),
        .value_next (min_next),
        .carry      (min_carry)
    );

    // Hours depend on the mode: 12 h runs 12,01..11 and flips PM on 11->12.
    always_comb begin
        hr_next = hms[23:16];
        pm_next = pm;
        if (min_carry) begin
            if (MODE12) begin
                if (hms[23:16] == HOUR12_MAX) begin
                    hr_next = 8'h01;
                end else if (hms[23:16] == 8'h11) begin
                    hr_next = HOUR12_MAX;
                    pm_next = ~pm;
                end else begin
                    hr_next = bcd_inc(hms[23:16]);
                end
            end else begin
                hr_next = (hms[23:16] == HOUR24_MAX) ? 8'h00 : bcd_inc(hms[23:16]);
            end
        end
    end

    always_ff @(posedge clko or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            count     <= '0;
            hms       <= RST_TIME;
            pm        <= 1'b0;
            pend_time <= RST_TIME;
            pend_pm   <= 1'b0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            ascii     <= to_ascii(RST_TIME);
        end else begin
            state     <= state_next;
            sec_pulse <= tick;
            set_err   <= (state == LOAD) && !load_ok;
            ascii     <= to_ascii(hms);
            if (accept) begin
                pend_time <= set_time;
                pend_pm   <= MODE12 && set_pm;
            end
            if (state == LOAD) begin
                if (load_ok) begin
                    hms   <= pend_time;
                    pm    <= pend_pm;
                    count <= '0;
                end
            end else if (tick) begin
                hms   <= {hr_next, min_next, sec_next};
                pm    <= pm_next;
                count <= '0;
            end else if (en) begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef BCD_TIME_KEEPER_ALARM_EN
    logic [24:0] alarm_reg;

    // sec_pulse marks a cycle whose hms came from a tick, so loads never fire.
    always_ff @(posedge clko or negedge rst) begin
        if (!rst) begin
            alarm_reg  <= {RST_TIME, 1'b0};
            alarm_fire <= 1'b0;
        end else begin
            if (alarm_we) begin
                alarm_reg <= {alarm_time, alarm_pm};
            end
            alarm_fire <= sec_pulse && ({hms, pm} == alarm_reg);
        end
    end
`endif

endmodule
